// File: rtl/pipe_skid_stage.sv
// Elastic pipeline-stage register: valid/ready handshake backed by a 2-entry skid buffer,
// so in_ready is a flop and the backward stall path is cut at every stage boundary.
module pipe_skid_stage #(
   parameter int unsigned       DATA_W     = 96,
   parameter bit                FLUSH_MODE = 1'b1,
   parameter logic [DATA_W-1:0] FLUSH_DATA = {32'h13, 64'h0},
   parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              flush,
   output logic [1:0]        occupancy
);

   // Encoding is {out_valid, skid_valid}; 2'b01 has no name because it must never occur.
   typedef enum logic [1:0] {
      S_EMPTY = 2'b00,
      S_ONE   = 2'b10,
      S_FULL  = 2'b11
   } state_t;

   typedef enum logic [1:0] {
      MAIN_HOLD,
      MAIN_IN,
      MAIN_SKID,
      MAIN_FLUSH
   } main_sel_t;

   state_t            r_state;
   state_t            w_state_nxt;
   main_sel_t         w_main_sel;
   logic              w_skid_load;
   logic              w_acc;
   logic              w_pop;
   logic [DATA_W-1:0] r_main;
   logic [DATA_W-1:0] r_skid;
   logic [1:0]        r_occupancy;
   logic [1:0]        w_occupancy_nxt;

   assign out_valid = r_state[1];
   assign in_ready  = ~r_state[0];
   assign out_data  = r_main;
   assign occupancy = r_occupancy;

   assign w_acc = in_valid & in_ready;
   assign w_pop = out_valid & out_ready;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_main_sel  = MAIN_HOLD;
      w_skid_load = 1'b0;
      if (flush) begin
         // A same-cycle pop has already been consumed downstream; a same-cycle accept is dropped.
         if (FLUSH_MODE) begin
            w_state_nxt = S_ONE;
            w_main_sel  = MAIN_FLUSH;
         end else begin
            w_state_nxt = S_EMPTY;
         end
      end else begin
         unique case (r_state)
            S_EMPTY: begin
               if (w_acc) begin
                  w_state_nxt = S_ONE;
                  w_main_sel  = MAIN_IN;
               end
            end
            S_ONE: begin
               if (w_acc && w_pop) begin
                  w_main_sel = MAIN_IN;
               end else if (w_acc) begin
                  w_skid_load = 1'b1;
                  w_state_nxt = S_FULL;
               end else if (w_pop) begin
                  w_state_nxt = S_EMPTY;
               end
            end
            S_FULL: begin
               if (w_pop) begin
                  w_main_sel  = MAIN_SKID;
                  w_state_nxt = S_ONE;
               end
            end
            default: w_state_nxt = S_EMPTY;
         endcase
      end
   end

   always_comb begin
      unique case (w_state_nxt)
         S_ONE:   w_occupancy_nxt = 2'd1;
         S_FULL:  w_occupancy_nxt = 2'd2;
         default: w_occupancy_nxt = 2'd0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_EMPTY;
         r_occupancy <= 2'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_occupancy <= w_occupancy_nxt;
      end
   end

   // NOTE: payload registers are reset too, because out_data has a defined post-reset value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main <= RESET_DATA;
         r_skid <= '0;
      end else begin
         unique case (w_main_sel)
            MAIN_IN:    r_main <= in_data;
            MAIN_SKID:  r_main <= r_skid;
            MAIN_FLUSH: r_main <= FLUSH_DATA;
            default:    r_main <= r_main;
         endcase
         if (w_skid_load) begin
            r_skid <= in_data;
         end
      end
   end

   a_no_orphan_skid : assert property (@(posedge clk) disable iff (!rst_n)
      !(!r_state[1] && r_state[0]));

   a_occupancy_consistent : assert property (@(posedge clk) disable iff (!rst_n)
      r_occupancy == ({1'b0, r_state[1]} + {1'b0, r_state[0]}));

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboarded bench for pipe_skid_stage: directed scenarios plus a long randomised handshake run.
// A second instance with FLUSH_MODE=0 covers the bubble-flush behaviour.
module tb_pipe_skid_stage;

   localparam int          DW  = 96;
   localparam logic [DW-1:0] NOP = {32'h13, 64'h0};

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready, out_valid;
   logic [DW-1:0] out_data;
   logic [1:0]    occupancy;

   logic          d0_in_valid = 1'b0, d0_out_ready = 1'b0, d0_flush = 1'b0;
   logic [DW-1:0] d0_in_data = '0;
   logic          d0_in_ready, d0_out_valid;
   logic [DW-1:0] d0_out_data;
   logic [1:0]    d0_occupancy;

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en   = 1'b0;
   logic [DW-1:0] q[$];

   pipe_skid_stage #(.DATA_W(DW), .FLUSH_MODE(1'b1), .FLUSH_DATA(NOP), .RESET_DATA('0)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .flush(flush), .occupancy(occupancy)
   );

   pipe_skid_stage #(.DATA_W(DW), .FLUSH_MODE(1'b0), .FLUSH_DATA(NOP), .RESET_DATA('0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(d0_in_valid), .in_ready(d0_in_ready), .in_data(d0_in_data),
      .out_valid(d0_out_valid), .out_ready(d0_out_ready), .out_data(d0_out_data),
      .flush(d0_flush), .occupancy(d0_occupancy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input bit iv, input logic [DW-1:0] d, input bit ordy, input bit fl);
      @(negedge clk);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
   endtask

   // Monitor: just before each rising edge, compare the DUT against the queue model, then
   // advance the model by whatever handshake/flush that edge will perform.
   initial begin
      bit acc_m;
      forever begin
         @(negedge clk);
         #4;
         if (mon_en && rst_n) begin
            check("out_valid", {95'd0, out_valid}, {95'd0, q.size() != 0});
            check("occupancy", {94'd0, occupancy}, DW'(q.size()));
            check("in_ready",  {95'd0, in_ready},  {95'd0, q.size() < 2});
            if (q.size() != 0) check("out_data", out_data, q[0]);
            acc_m = in_valid && (q.size() < 2);
            if (out_ready && q.size() != 0) void'(q.pop_front());
            if (flush) begin
               q.delete();
               q.push_back(NOP);
            end else if (acc_m) begin
               q.push_back(in_data);
            end
         end
      end
   end

   initial begin
      #3;
      check("rst out_valid", {95'd0, out_valid}, '0);
      check("rst out_data",  out_data, '0);
      check("rst in_ready",  {95'd0, in_ready}, DW'(1));
      check("rst occupancy", {94'd0, occupancy}, '0);
      check("rst d0 out_valid", {95'd0, d0_out_valid}, '0);
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Streaming with out_ready held high: one cycle latency, no bubbles.
      cyc(1, 96'hA, 1, 0);
      cyc(1, 96'hB, 1, 0);
      #3 check("stream first", out_data, 96'hA);
      cyc(1, 96'hC, 1, 0);
      cyc(0, '0, 1, 0);
      #3 check("stream last", out_data, 96'hC);
      check("stream occ", {94'd0, occupancy}, DW'(1));
      cyc(0, '0, 1, 0);

      // Fill the skid, hold, then drain in order.
      cyc(1, 96'h1, 1, 0);
      cyc(1, 96'h2, 0, 0);
      cyc(0, '0, 0, 0);
      #3 check("full in_ready", {95'd0, in_ready}, '0);
      check("full occ", {94'd0, occupancy}, DW'(2));
      check("full head", out_data, 96'h1);
      cyc(0, '0, 0, 0);
      cyc(0, '0, 1, 0);
      #3 check("drain first", out_data, 96'h1);
      cyc(0, '0, 1, 0);
      #3 check("drain second", out_data, 96'h2);
      check("drain in_ready", {95'd0, in_ready}, DW'(1));
      cyc(0, '0, 1, 0);

      // NOP-injecting flush while full, with a competing accept.
      cyc(1, 96'h5, 0, 0);
      cyc(1, 96'h6, 0, 0);
      cyc(1, 96'h7, 0, 1);
      cyc(0, '0, 0, 0);
      #3 check("flush nop data", out_data, NOP);
      check("flush nop valid", {95'd0, out_valid}, DW'(1));
      check("flush in_ready", {95'd0, in_ready}, DW'(1));
      check("flush occ", {94'd0, occupancy}, DW'(1));
      cyc(0, '0, 0, 0);
      #3 check("nop stable", out_data, NOP);
      cyc(0, '0, 1, 0);
      cyc(0, '0, 1, 0);
      #3 check("nop drained", {95'd0, out_valid}, '0);

      // Bubble flush on the FLUSH_MODE=0 instance, coinciding with a pop.
      @(negedge clk);
      d0_in_valid = 1'b1; d0_in_data = 96'h9;
      @(negedge clk);
      d0_in_valid = 1'b0; d0_flush = 1'b1; d0_out_ready = 1'b1;
      #3 check("d0 pop valid", {95'd0, d0_out_valid}, DW'(1));
      check("d0 pop data", d0_out_data, 96'h9);
      @(negedge clk);
      d0_flush = 1'b0; d0_out_ready = 1'b0;
      #3 check("d0 bubble valid", {95'd0, d0_out_valid}, '0);
      check("d0 bubble occ", {94'd0, d0_occupancy}, '0);
      check("d0 bubble in_ready", {95'd0, d0_in_ready}, DW'(1));
      check("d0 bubble hold", d0_out_data, 96'h9);

      // Asynchronous reset while full.
      cyc(1, 96'h11, 0, 0);
      cyc(1, 96'h12, 0, 0);
      cyc(0, '0, 0, 0);
      #2 rst_n = 1'b0;
      q.delete();
      #1 check("arst out_valid", {95'd0, out_valid}, '0);
      check("arst out_data", out_data, '0);
      check("arst in_ready", {95'd0, in_ready}, DW'(1));
      check("arst occ", {94'd0, occupancy}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1, 96'h3, 1, 0);
      cyc(0, '0, 1, 0);
      #3 check("post-rst latency", out_data, 96'h3);
      check("post-rst valid", {95'd0, out_valid}, DW'(1));
      cyc(0, '0, 1, 0);

      // Random handshake traffic with occasional flushes.
      for (int i = 0; i < 10000; i++) begin
         cyc(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom},
             1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0);
      end
      repeat (4) cyc(0, '0, 1, 0);
      mon_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
